// File: rtl/vga_score_pkg.sv
// rtl/vga_score_pkg.sv - shared types, segment glyphs and default geometry for the score display
package vga_score_pkg;

  typedef logic [6:0] seg7_t;  // {A,B,C,D,E,F,G}

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1110011;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  localparam int DEF_NDIGITS   = 4;
  localparam int DEF_SCORE_W   = 14;
  localparam int DEF_XOFFSET   = 560;
  localparam int DEF_YOFFSET   = 16;
  localparam int DEF_DIG_W     = 16;
  localparam int DEF_DIG_H     = 32;
  localparam int DEF_SEG_T     = 4;
  localparam int DEF_DIG_PITCH = 20;
  localparam logic [2:0] DEF_COLOR = 3'b111;

  // Largest value that fits in ndigits decimal digits, in 64-bit precision.
  function automatic logic [63:0] max_value(input int ndigits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < ndigits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/vga_seg7_decode.sv
// rtl/vga_seg7_decode.sv - BCD nibble to seven-segment glyph; non-decimal nibbles are blank
module vga_seg7_decode
  import vga_score_pkg::*;
(
  input  logic [3:0] digit_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/vga_score_display.sv
// rtl/vga_score_display.sv - double-dabble score converter with frame-synchronous commit and 7-seg renderer
// Optional leading-zero blanking when SCORE_LZB_EN is defined.
module vga_score_display
  import vga_score_pkg::*;
#(
  parameter int         NDIGITS   = DEF_NDIGITS,
  parameter int         SCORE_W   = DEF_SCORE_W,
  parameter int         XOFFSET   = DEF_XOFFSET,
  parameter int         YOFFSET   = DEF_YOFFSET,
  parameter int         DIG_W     = DEF_DIG_W,
  parameter int         DIG_H     = DEF_DIG_H,
  parameter int         SEG_T     = DEF_SEG_T,
  parameter int         DIG_PITCH = DEF_DIG_PITCH,
  parameter logic [2:0] COLOR     = DEF_COLOR
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  input  logic               frame_start,
  input  logic [9:0]         row,
  input  logic [9:0]         col,
  output logic [2:0]         rgb_out
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [63:0]        MAXV      = max_value(NDIGITS);
  localparam logic [SCORE_W-1:0] MAXV_T    = SCORE_W'(MAXV);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCORE_W - 1);

  localparam logic [10:0] Y0   = 11'(YOFFSET);
  localparam logic [10:0] Y1   = 11'(YOFFSET + DIG_H);
  localparam logic [9:0]  Y0S  = 10'(YOFFSET);
  localparam logic [9:0]  T    = 10'(SEG_T);
  localparam logic [9:0]  W_T  = 10'(DIG_W - SEG_T);
  localparam logic [9:0]  HALF = 10'(DIG_H / 2);
  localparam logic [9:0]  G_LO = 10'((DIG_H - SEG_T) / 2);
  localparam logic [9:0]  G_HI = 10'((DIG_H + SEG_T) / 2);
  localparam logic [9:0]  D_LO = 10'(DIG_H - SEG_T);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [SCORE_W-1:0]  shreg_q, shreg_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [SCORE_W-1:0]  hold_q;
  logic                hold_v_q;
  logic [BCD_W-1:0]    pend_q, disp_q;
  logic                pending_q;
  logic                busy_q;
  logic [2:0]          rgb_q;
  logic [SCORE_W-1:0]  src, src_sat;
  logic [NDIGITS-1:0]  blank, lit;

  // A fresh strobe in IDLE beats a held value: it is the newer score.
  always_comb begin
    src     = score_valid ? score : hold_q;
    src_sat = (64'(src) > MAXV) ? MAXV_T : src;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
  end

  always_comb begin
    blank = '0;
`ifdef SCORE_LZB_EN
    for (int k = 0; k < NDIGITS - 1; k++) begin
      blank[k] = (k == 0) ? (disp_q[4*(NDIGITS-1) +: 4] == 4'd0)
                          : (blank[k-1] && (disp_q[4*(NDIGITS-1-k) +: 4] == 4'd0));
    end
`endif
  end

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    localparam logic [10:0] X0  = 11'(XOFFSET + k * DIG_PITCH);
    localparam logic [10:0] X1  = 11'(XOFFSET + k * DIG_PITCH + DIG_W);
    localparam logic [9:0]  X0S = 10'(XOFFSET + k * DIG_PITCH);
    seg7_t      seg;
    logic       in_win, top;
    logic [9:0] x, y;

    vga_seg7_decode u_dec (
      .digit_i (disp_q[4*(NDIGITS-1-k) +: 4]),
      .seg_o   (seg)
    );

    // Window test runs on unsigned 11-bit values before any subtraction.
    assign in_win = ({1'b0, col} >= X0) && ({1'b0, col} < X1) &&
                    ({1'b0, row} >= Y0) && ({1'b0, row} < Y1);
    assign x   = col - X0S;
    assign y   = row - Y0S;
    assign top = (y < HALF);
    assign lit[k] = in_win && !blank[k] && (
                      (seg[6] && (y < T)) ||
                      (seg[5] && (x >= W_T) && top) ||
                      (seg[4] && (x >= W_T) && !top) ||
                      (seg[3] && (y >= D_LO)) ||
                      (seg[2] && (x < T) && !top) ||
                      (seg[1] && (x < T) && top) ||
                      (seg[0] && (y >= G_LO) && (y < G_HI)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bcd_q     <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      pend_q    <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      rgb_q     <= 3'b000;
    end else begin
      rgb_q <= (|lit) ? COLOR : 3'b000;
      if (frame_start && pending_q) begin
        disp_q    <= pend_q;
        pending_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (score_valid || hold_v_q) begin
            shreg_q  <= src_sat;
            bcd_q    <= '0;
            cnt_q    <= '0;
            hold_v_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q   <= bcd_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (score_valid) begin
            hold_q   <= score;
            hold_v_q <= 1'b1;
          end
          // Finishing wins over a same-edge commit so the new result stays pending.
          if (cnt_q == CNT_LAST) begin
            pend_q    <= bcd_d;
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_vga_score_display.sv
// tb/tb_vga_score_display.sv - randomized self-checking bench for vga_score_display
module tb_vga_score_display;

  logic        clk = 1'b0;
  logic        reset, score_valid, frame_start, busy;
  logic [13:0] score;
  logic [9:0]  row, col;
  logic [2:0]  rgb_out;

  int n_checks = 0;
  int n_pass   = 0;
  int disp_val = 0;

  logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  always #5 clk = ~clk;

  vga_score_display dut (
    .clk         (clk),
    .reset       (reset),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .frame_start (frame_start),
    .row         (row),
    .col         (col),
    .rgb_out     (rgb_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  // Expected pixel colour for a displayed value, straight from the glyph geometry.
  function automatic logic [2:0] model_pix(int val, int r, int c);
    int  d [4];
    int  div;
    bit  lead;
    div  = 1000;
    lead = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d[k] = (val / div) % 10;
      div  = div / 10;
    end
    for (int k = 0; k < 4; k++) begin
      int lx, ly;
      logic [6:0] s;
      bit top, left, right;
      lead = lead && (d[k] == 0);
`ifdef SCORE_LZB_EN
      if (lead && k < 3) continue;
`endif
      lx = c - (560 + 20 * k);
      ly = r - 16;
      if (lx < 0 || lx >= 16 || ly < 0 || ly >= 32) continue;
      s     = segtab[d[k]];
      top   = ly < 16;
      left  = lx < 4;
      right = lx >= 12;
      if ((s[6] && ly < 4) || (s[0] && ly >= 14 && ly < 18) || (s[3] && ly >= 28) ||
          (s[1] && left && top) || (s[5] && right && top) ||
          (s[2] && left && !top) || (s[4] && right && !top))
        return 3'b111;
    end
    return 3'b000;
  endfunction

  task automatic strobe(int s);
    score       = 14'(s);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_render(string tag, int n);
    for (int i = 0; i < n; i++) begin
      int r, c;
      logic [2:0] exp;
      if (i % 8 == 0) begin
        r = $urandom_range(0, 1023);
        c = $urandom_range(0, 1023);
      end else begin
        r = $urandom_range(10, 52);
        c = $urandom_range(552, 644);
      end
      row = 10'(r);
      col = 10'(c);
      tick();
      exp = model_pix(disp_val, r, c);
      n_checks++;
      if (rgb_out !== exp)
        $display("FAIL %s pixel r=%0d c=%0d val=%0d: got %b want %b", tag, r, c, disp_val, rgb_out, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; score_valid = 1'b0; frame_start = 1'b0;
    score = '0; row = 10'd17; col = 10'd574;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (rgb_out !== 3'b000) $display("FAIL reset_rgb: got %b want 000", rgb_out); else n_pass++;
    reset = 1'b0;
    disp_val = 0;
    tick();
    n_checks++;
    if (rgb_out !== model_pix(0, 17, 574))
      $display("FAIL reset_disp: got %b want %b", rgb_out, model_pix(0, 17, 574));
    else n_pass++;
    test_render("reset", 60);
  endtask

  task automatic test_basic();
    int nb;
    strobe(1234);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      nb++;
      tick();
    end
    n_checks++;
    if (nb != 14) $display("FAIL busy_len: got %0d want 14", nb); else n_pass++;
    frame();
    disp_val = 1234;
    row = 10'd17; col = 10'd574; tick();
    n_checks++;
    if (rgb_out !== 3'b111) $display("FAIL d0_segB: got %b want 111", rgb_out); else n_pass++;
    row = 10'd17; col = 10'd562; tick();
    n_checks++;
    if (rgb_out !== 3'b000) $display("FAIL d0_segA: got %b want 000", rgb_out); else n_pass++;
    test_render("basic", 150);
  endtask

  task automatic test_saturate();
    strobe(16383);
    for (int i = 0; i < 40 && busy; i++) tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL sat_timeout: busy got %b want 0", busy); else n_pass++;
    frame();
    disp_val = 9999;
    row = 10'd31; col = 10'd628; tick();
    n_checks++;
    if (rgb_out !== 3'b111) $display("FAIL sat_d3_segG: got %b want 111", rgb_out); else n_pass++;
    test_render("saturate", 150);
  endtask

  task automatic test_back_to_back();
    logic [34:0] got, exp;
    for (int i = 0; i < 35; i++) exp[i] = (i < 14) || (i >= 15 && i < 29);
    strobe(42);
    for (int i = 0; i < 35; i++) begin
      got[i] = busy;
      score_valid = (i == 4);
      score = (i == 4) ? 14'd77 : 14'd0;
      tick();
    end
    score_valid = 1'b0;
    n_checks++;
    if (got !== exp) $display("FAIL b2b_busy: got %b want %b", got, exp); else n_pass++;
    test_render("b2b_before_frame", 60);
    frame();
    disp_val = 77;
    test_render("b2b_after_frame", 150);
  endtask

  task automatic test_frame_boundary();
    int old_val;
    old_val = disp_val;
    strobe(2468);
    for (int i = 0; i < 13; i++) tick();
    frame();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL fb_busy: got %b want 0", busy); else n_pass++;
    disp_val = old_val;
    test_render("fb_same_edge", 80);
    frame();
    disp_val = 2468;
    test_render("fb_next_frame", 80);
  endtask

  task automatic test_lzb();
    logic [2:0] exp;
    strobe(7);
    for (int i = 0; i < 40 && busy; i++) tick();
    frame();
    disp_val = 7;
`ifdef SCORE_LZB_EN
    exp = 3'b000;
`else
    exp = 3'b111;
`endif
    row = 10'd17; col = 10'd562; tick();
    n_checks++;
    if (rgb_out !== exp) $display("FAIL lzb_d0_segA: got %b want %b", rgb_out, exp); else n_pass++;
    row = 10'd17; col = 10'd626; tick();
    n_checks++;
    if (rgb_out !== 3'b111) $display("FAIL lzb_d3_segA: got %b want 111", rgb_out); else n_pass++;
    test_render("lzb", 150);
  endtask

  task automatic test_reset_mid();
    strobe(5555);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    for (int i = 0; i < 20; i++) tick();
    frame();
    disp_val = 0;
    test_render("rstmid", 100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int s;
      s = (n == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 16383);
      strobe(s);
      for (int i = 0; i < 40 && busy; i++) tick();
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand_timeout: busy got %b want 0", busy); else n_pass++;
      frame();
      disp_val = sat(s);
      test_render("random", 150);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_frame_boundary();
    test_lzb();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
